instr_fetch: RTL and testbench

Instruction-fetch stage of the pipelined RV32I CPU. Owns the fetch PC register (PCF) and drives the instruction-memory request/response handshake. It hands fetched instructions to decode through the IF/ID pipeline register. The fetch PC is taken from the next-PC selector, and PCF is fed back to that selector; execute-stage redirects (branch, JAL, JALR) and decode stalls are handled here, including a redirect that arrives while a memory access is still outstanding.

---
 rtl/instr_fetch_if.sv | 27 ++
 rtl/instr_fetch.sv | 122 ++++++++++++
 tb/tb_instr_fetch.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and
// the instruction memory (slave).
interface instr_fetch_if #(
  parameter int WIDTH = 32
);
  // Handshake: one outstanding request. Req and Addr stay constant from the cycle
  // Req rises until the edge where Rvalid is sampled high. Rdata is valid only with
  // Rvalid, and Rvalid may be high in the very first cycle of a request.
  logic             Imem_Req_o;
  logic [WIDTH-1:0] Imem_Addr_o;
  logic             Imem_Rvalid_i;
  logic [WIDTH-1:0] Imem_Rdata_i;

  modport master (
    output Imem_Req_o,
    output Imem_Addr_o,
    input  Imem_Rvalid_i,
    input  Imem_Rdata_i
  );

  modport slave (
    input  Imem_Req_o,
    input  Imem_Addr_o,
    output Imem_Rvalid_i,
    output Imem_Rdata_i
  );
endinterface

// File: rtl/instr_fetch.sv
// RV32I fetch stage: owns PCF, runs the instruction-memory handshake and loads the
// IF/ID register, absorbing decode stalls and execute redirects.
module instr_fetch #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  PC_Next_i,
  input  logic              Redirect_i,
  input  logic              Stall_i,
  output logic [WIDTH-1:0]  PC_o,
  instr_fetch_if.master     imem,
  output logic [WIDTH-1:0]  Instr_D_o,
  output logic [WIDTH-1:0]  PC_D_o,
  output logic [WIDTH-1:0]  PC_Plus4_D_o,
  output logic              Valid_D_o,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    FETCH   = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t           state;
  logic             req_q;
  logic [WIDTH-1:0] pcf;
  logic [WIDTH-1:0] fb_instr;
  logic [WIDTH-1:0] fb_pc;
  logic [WIDTH-1:0] tgt;

  assign PC_o             = pcf;
  assign imem.Imem_Addr_o = pcf;
  assign imem.Imem_Req_o  = req_q;
  assign dbg_state        = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= BOOT;
      req_q        <= 1'b0;
      pcf          <= RESET_PC;
      fb_instr     <= '0;
      fb_pc        <= '0;
      tgt          <= '0;
      Instr_D_o    <= '0;
      PC_D_o       <= '0;
      PC_Plus4_D_o <= '0;
      Valid_D_o    <= 1'b0;
    end else begin
      // IF/ID default: flush on redirect, hold on stall, otherwise bubble unless a
      // state branch below writes an instruction (later assignment wins).
      if (Redirect_i || !Stall_i) begin
        Valid_D_o <= 1'b0;
      end

      case (state)
        BOOT: begin
          state <= FETCH;
          req_q <= 1'b1;
        end

        FETCH: begin
          if (imem.Imem_Rvalid_i) begin
            if (Redirect_i) begin
              pcf <= PC_Next_i;
            end else if (!Stall_i) begin
              Instr_D_o    <= imem.Imem_Rdata_i;
              PC_D_o       <= pcf;
              PC_Plus4_D_o <= pcf + WIDTH'(4);
              Valid_D_o    <= 1'b1;
              pcf          <= PC_Next_i;
            end else begin
              fb_instr <= imem.Imem_Rdata_i;
              fb_pc    <= pcf;
              state    <= HOLD;
              req_q    <= 1'b0;
            end
          end else if (Redirect_i) begin
            // Request cannot be withdrawn: remember the target and wait it out.
            tgt   <= PC_Next_i;
            state <= DISCARD;
          end
        end

        HOLD: begin
          if (Redirect_i) begin
            pcf   <= PC_Next_i;
            state <= FETCH;
            req_q <= 1'b1;
          end else if (!Stall_i) begin
            Instr_D_o    <= fb_instr;
            PC_D_o       <= fb_pc;
            PC_Plus4_D_o <= fb_pc + WIDTH'(4);
            Valid_D_o    <= 1'b1;
            pcf          <= PC_Next_i;
            state        <= FETCH;
            req_q        <= 1'b1;
          end
        end

        DISCARD: begin
          if (Redirect_i) begin
            tgt <= PC_Next_i;
          end
          if (imem.Imem_Rvalid_i) begin
            pcf   <= Redirect_i ? PC_Next_i : tgt;
            state <= FETCH;
          end
        end

        default: begin
          state <= BOOT;
          req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios with literal expectations,
// then randomized memory latency, stalls and redirects against a transaction model.
module tb_instr_fetch;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] pc_next;
  logic         redirect;
  logic         stall;
  logic [W-1:0] pc_o;
  logic [W-1:0] instr_d;
  logic [W-1:0] pc_d;
  logic [W-1:0] pc_plus4_d;
  logic         valid_d;
  logic [1:0]   dbg_state;

  instr_fetch_if #(.WIDTH(W)) imem_if ();

  instr_fetch #(.WIDTH(W), .RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .PC_Next_i    (pc_next),
    .Redirect_i   (redirect),
    .Stall_i      (stall),
    .PC_o         (pc_o),
    .imem         (imem_if),
    .Instr_D_o    (instr_d),
    .PC_D_o       (pc_d),
    .PC_Plus4_D_o (pc_plus4_d),
    .Valid_D_o    (valid_d),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] data_key = '0;

  // ---------------- behavioural model ----------------
  // Transaction view: is a request live, is it stale (redirected away), is a
  // fetched word parked waiting for decode, and what decode currently sees.
  logic         m_boot;
  logic         m_req;
  logic [W-1:0] m_pc;
  logic         m_stale;
  logic [W-1:0] m_target;
  logic         m_parked;
  logic [W-1:0] m_park_instr;
  logic [W-1:0] m_park_pc;
  logic         m_dvalid;
  logic [W-1:0] m_dinstr;
  logic [W-1:0] m_dpc;

  task automatic model_reset();
    m_boot = 1'b1; m_req = 1'b0; m_pc = '0; m_stale = 1'b0; m_target = '0;
    m_parked = 1'b0; m_park_instr = '0; m_park_pc = '0;
    m_dvalid = 1'b0; m_dinstr = '0; m_dpc = '0;
  endtask

  task automatic model_step(input logic rv, input logic [W-1:0] rd, input logic rdr,
                            input logic stl, input logic [W-1:0] nxt);
    logic         issue;
    logic [W-1:0] w_instr;
    logic [W-1:0] w_pc;
    issue = 1'b0; w_instr = '0; w_pc = '0;
    if (m_boot) begin
      m_boot = 1'b0;
      m_req  = 1'b1;
    end else if (m_parked) begin
      if (rdr || !stl) begin
        if (!rdr) begin
          issue = 1'b1; w_instr = m_park_instr; w_pc = m_park_pc;
        end
        m_parked = 1'b0;
        m_pc     = nxt;
        m_req    = 1'b1;
      end
    end else if (m_stale) begin
      if (rdr) m_target = nxt;
      if (rv) begin
        m_pc    = m_target;
        m_stale = 1'b0;
      end
    end else if (rv) begin
      if (rdr) m_pc = nxt;
      else if (!stl) begin
        issue = 1'b1; w_instr = rd; w_pc = m_pc;
        m_pc = nxt;
      end else begin
        m_parked = 1'b1; m_park_instr = rd; m_park_pc = m_pc;
        m_req = 1'b0;
      end
    end else if (rdr) begin
      m_stale  = 1'b1;
      m_target = nxt;
    end
    if (rdr) m_dvalid = 1'b0;
    else if (!stl) begin
      m_dvalid = issue;
      if (issue) begin
        m_dinstr = w_instr;
        m_dpc    = w_pc;
      end
    end
  endtask

  // ---------------- scoreboard / compare ----------------
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("req",     W'(imem_if.Imem_Req_o), W'(m_req));
    chk("addr",    imem_if.Imem_Addr_o, m_pc);
    chk("pc_o",    pc_o, m_pc);
    chk("valid_d", W'(valid_d), W'(m_dvalid));
    if (m_dvalid) begin
      chk("instr_d",    instr_d, m_dinstr);
      chk("pc_d",       pc_d, m_dpc);
      chk("pc_plus4_d", pc_plus4_d, m_dpc + 32'd4);
    end
  endtask

  function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
    return a ^ data_key;
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge: present inputs, clock one edge, step model, compare.
  task automatic drive(input logic rv, input logic rdr, input logic stl,
                       input logic [W-1:0] tgt);
    imem_if.Imem_Rvalid_i = rv;
    imem_if.Imem_Rdata_i  = mem_word(imem_if.Imem_Addr_o);
    redirect = rdr;
    stall    = stl;
    pc_next  = rdr ? tgt : pc_o + 32'd4;
    @(posedge clk);
    model_step(rv, imem_if.Imem_Rdata_i, rdr, stl, pc_next);
    @(negedge clk);
    compare_model();
  endtask

  logic [W-1:0] stream_exp[4];

  initial begin
    rst_n = 1'b0; redirect = 1'b0; stall = 1'b0; pc_next = '0;
    imem_if.Imem_Rvalid_i = 1'b0; imem_if.Imem_Rdata_i = '0;
    model_reset();
    stream_exp[0] = 32'h0; stream_exp[1] = 32'h4; stream_exp[2] = 32'h8; stream_exp[3] = 32'hC;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_req",   W'(imem_if.Imem_Req_o), 32'd0);
    chk("rst_pc",    pc_o, 32'h0);
    chk("rst_valid", W'(valid_d), 32'd0);
    chk("rst_instr", instr_d, 32'h0);
    chk("rst_state", W'(dbg_state), 32'd0);
    rst_n = 1'b1;

    // First request one cycle after release
    drive(1'b0, 1'b0, 1'b0, '0);
    chk("first_req",  W'(imem_if.Imem_Req_o), 32'd1);
    chk("first_addr", imem_if.Imem_Addr_o, 32'h0);

    // Zero-wait stream, Rdata = Addr
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, '0);
      chk("zw_instr", instr_d, stream_exp[i]);
      chk("zw_valid", W'(valid_d), 32'd1);
      chk("zw_plus4", pc_plus4_d, stream_exp[i] + 32'd4);
    end

    // Stall on response at Addr=10, held two cycles
    drive(1'b1, 1'b0, 1'b1, '0);
    chk("stall_req",   W'(imem_if.Imem_Req_o), 32'd0);
    chk("stall_instr", instr_d, 32'hC);
    drive(1'b0, 1'b0, 1'b1, '0);
    chk("stall2_req",  W'(imem_if.Imem_Req_o), 32'd0);
    drive(1'b0, 1'b0, 1'b0, '0);
    chk("rel_instr", instr_d, 32'h10);
    chk("rel_pc",    pc_d, 32'h10);
    chk("rel_addr",  imem_if.Imem_Addr_o, 32'h14);

    // Redirect during a wait state on Addr=14
    drive(1'b0, 1'b1, 1'b0, 32'h100);
    chk("wr_addr",  imem_if.Imem_Addr_o, 32'h14);
    chk("wr_valid", W'(valid_d), 32'd0);
    drive(1'b0, 1'b0, 1'b0, '0);
    chk("wr_addr2", imem_if.Imem_Addr_o, 32'h14);
    drive(1'b1, 1'b0, 1'b0, '0);
    chk("wr_valid2", W'(valid_d), 32'd0);
    chk("wr_target", imem_if.Imem_Addr_o, 32'h100);

    // Double redirect while discarding: newest target wins
    drive(1'b0, 1'b1, 1'b0, 32'h100);
    drive(1'b0, 1'b1, 1'b0, 32'h200);
    drive(1'b1, 1'b0, 1'b0, '0);
    chk("dbl_target", imem_if.Imem_Addr_o, 32'h200);

    // Redirect and stall together flush IF/ID
    drive(1'b1, 1'b0, 1'b0, '0);
    chk("rs_pre_valid", W'(valid_d), 32'd1);
    drive(1'b0, 1'b1, 1'b1, 32'h400);
    chk("rs_valid", W'(valid_d), 32'd0);
    drive(1'b1, 1'b0, 1'b0, '0);
    chk("rs_target", imem_if.Imem_Addr_o, 32'h400);

    // PC+4 wraps at the top of the address space
    drive(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC);
    drive(1'b1, 1'b0, 1'b0, '0);
    chk("wrap_pc",    pc_d, 32'hFFFF_FFFC);
    chk("wrap_plus4", pc_plus4_d, 32'h0);
    chk("wrap_addr",  imem_if.Imem_Addr_o, 32'h0);

    // Asynchronous reset in the middle of a discard
    drive(1'b0, 1'b1, 1'b0, 32'h500);
    chk("ar_state_pre", W'(dbg_state), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_req",   W'(imem_if.Imem_Req_o), 32'd0);
    chk("ar_pc",    pc_o, 32'h0);
    chk("ar_valid", W'(valid_d), 32'd0);
    chk("ar_state", W'(dbg_state), 32'd0);
    redirect = 1'b0; imem_if.Imem_Rvalid_i = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic
    data_key = $urandom();
    for (int n = 0; n < 3000; n++) begin
      logic         rv;
      logic         rdr;
      logic         stl;
      logic [W-1:0] tgt;
      rv  = m_req && ($urandom_range(0, 2) != 0);
      rdr = ($urandom_range(0, 7) == 0);
      stl = ($urandom_range(0, 3) == 0);
      tgt = $urandom();
      if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
      drive(rv, rdr, stl, tgt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
